// File: rtl/dmem_word_responder.sv
// Big-endian byte-array data memory for word loads and stores.
// Each word access is split into four single-byte beats.
module dmem_word_responder #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_write,
  input  logic [AW-1:0] dbg_addr,
  output logic [7:0]    dbg_data
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [31:0]   wdata_q;
  logic [1:0]    idx_q;
  logic [23:0]   shift_q;

  logic [AW-1:0] baddr;
  logic [7:0]    wbyte;
  logic [7:0]    rbyte;
  logic          accept;
  logic          last;

  // Byte address wraps naturally at AW bits
  assign baddr  = addr_q + {{(AW-2){1'b0}}, idx_q};
  assign rbyte  = mem[baddr];
  assign last   = (idx_q == 2'd3);
  assign accept = req_valid & req_ready;

  assign dbg_data = mem[dbg_addr];

  always_comb begin
    wbyte = 8'h00;
    unique case (idx_q)
      2'd0: wbyte = wdata_q[31:24];
      2'd1: wbyte = wdata_q[23:16];
      2'd2: wbyte = wdata_q[15:8];
      2'd3: wbyte = wdata_q[7:0];
    endcase
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = XFER;
      end
      XFER: begin
        if (last) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      rsp_rdata <= '0;
      rsp_write <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= req_addr;
        write_q <= req_write;
        wdata_q <= req_wdata;
        idx_q   <= '0;
      end else if (state == XFER) begin
        idx_q <= idx_q + 2'd1;
        if (!write_q) shift_q <= {shift_q[15:0], rbyte};
        if (last) begin
          rsp_rdata <= write_q ? 32'h0 : {shift_q, rbyte};
          rsp_write <= write_q;
        end
      end
    end
  end

  // Array is deliberately not reset; an aborted store keeps its beats
  always_ff @(posedge clk) begin
    if (state == XFER && write_q) mem[baddr] <= wbyte;
  end

endmodule
